ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX→MEM pipeline boundary register with stall, bubble and flush control. It carries N write-back lanes, HI/LO results and the multi-cycle multiply/divide scratch state (partial product and step counter) across the boundary. Two saturating stall/bubble performance counters are added. It sits between the execute unit and the memory-access stage and is driven by the central stall controller's per-stage stall vector plus the exception unit's flush.

## Interface
Parameters:
- STAGE, 3: index of this stage in the stall vector; STAGE+1 is the downstream stage. Elaboration error if STAGE+1 ≥ CTRL_WIDTH.
- CTRL_WIDTH, 6: stall vector width.
- LANES, 1: number of write-back lanes (1..4).
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- TMP_W, 64: multi-cycle scratch width (2·DATA_W).
- CNT_W, 2: multi-cycle step counter width.
- ZERO_SUPPRESS, 1: when 1, a lane with address 0 never asserts its write enable downstream.
- PERF_W, 16: performance counter width.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  CTRL_WIDTH  per-stage stall vector.
- flush  in  1  exception flush; kills the stage contents.
- perf_clr  in  1  synchronous clear of both perf counters.
- valid_in  in  1  EX result valid.
- wb_addr_in  in  LANES·ADDR_W  packed lane addresses; lane i at bits [i·ADDR_W +: ADDR_W].
- wb_data_in  in  LANES·DATA_W  packed lane data.
- wb_en_in  in  LANES  lane write enables.
- hi_in, lo_in  in  DATA_W  HI/LO results.
- hilo_wen_in  in  1  HI/LO write enable.
- tmp_in  in  TMP_W  scratch fed back from EX.
- cnt_in  in  CNT_W  step count fed back from EX.
- valid_out  out  1  and wb_addr_out / wb_data_out / wb_en_out / hi_out / lo_out / hilo_wen_out: registered counterparts of the inputs, same widths.
- tmp_out  out  TMP_W  and cnt_out  out  CNT_W: registered scratch state to EX.
- stall_cycles  out  PERF_W  saturating count of cycles with stall[STAGE]=1.
- bubble_cycles  out  PERF_W  saturating count of bubble insertions.

## Operation
- Priority per edge: rst > flush > bubble > advance > hold.
- rst (async): all outputs, including counters, go to 0.
- flush: payload, valid_out, tmp_out and cnt_out all go to 0. Counters are not incremented.
- bubble (stall[STAGE]=1, stall[STAGE+1]=0): payload and valid_out go to 0. tmp_out←tmp_in, cnt_out←cnt_in. bubble_cycles increments.
- advance (stall[STAGE]=0): payload←inputs; valid_out←valid_in. Lane enable out = wb_en_in[i] & valid_in & !(ZERO_SUPPRESS && addr==0). hilo_wen_out = hilo_wen_in & valid_in. tmp_out and cnt_out go to 0.
- hold (stall[STAGE]=1, stall[STAGE+1]=1): payload and valid_out unchanged. tmp_out←tmp_in, cnt_out←cnt_in.
- stall_cycles increments on any non-flush cycle with stall[STAGE]=1.
- Both counters saturate at all-ones; they never wrap.
- perf_clr: both counters go to 0. If perf_clr and an increment fall in the same cycle, clear wins. Flush and clear in the same cycle gives 0.

## Timing
- Latency is 1 cycle input→output on advance. There is no combinational path from input to output.
- Scratch loop: EX sees tmp_out/cnt_out one cycle after presenting tmp_in/cnt_in during a stall.
- A flush during a multi-cycle operation discards the scratch in the same edge. EX must restart the operation from cnt=0.
- Deassertion of rst is synchronised externally; the block assumes no edge-recovery hazard.

## Structure
- Shared package pipe_pkg holds:
  - stall-index constants (STG_IF..STG_WB, with EX/MEM boundary = 3);
  - CTRL_WIDTH, REG_ADDR_WIDTH, REG_DATA_WIDTH, DOUBLE_DATA_WIDTH.
- Sub-module sat_counter (parameter W; inputs inc and clr; clr has priority). It is instantiated twice, once for stall_cycles and once for bubble_cycles.
- Lane handling is a generate loop; no per-lane state beyond the registers.

## Test plan
- Reset mid-operation: advance with data=0xDEADBEEF and cnt_in=2, then assert rst asynchronously between edges. All outputs read 0 immediately, before the next edge.
- Advance with LANES=2, lane0 addr=0 en=1 and lane1 addr=7 en=1 data=0x1234, ZERO_SUPPRESS=1. Next cycle: wb_en_out=2'b10, wb_data_out lane1=0x1234, valid_out=1.
- Bubble: stall[3]=1, stall[4]=0, tmp_in=0x0000_0001_0000_0002, cnt_in=1. Result: valid_out=0, all enables 0, tmp_out=tmp_in, cnt_out=1, bubble_cycles +1.
- Hold 3 cycles with stall[3]=stall[4]=1 after an advance of data 0xA5. Payload stays 0xA5; stall_cycles +3; bubble_cycles unchanged.
- Flush during a stall with cnt_out=2. Next cycle: tmp_out=0, cnt_out=0, valid_out=0, and stall_cycles is not incremented that cycle.
- With PERF_W=4, stall for 20 cycles: stall_cycles saturates at 15. Then assert perf_clr together with a stall: result is 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stall indices, widths and stage-operation encoding.
package pipe_pkg;
  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB = 5;
  localparam int CTRL_WIDTH = 6;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int DOUBLE_DATA_WIDTH = 2 * REG_DATA_WIDTH;
  typedef enum logic [1:0] {OP_HOLD, OP_ADV, OP_BUBBLE, OP_FLUSH} stage_op_e;
endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM boundary register with flush/bubble/hold control, multi-cycle
// scratch feedback and saturating stall/bubble counters.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int STAGE = STG_EX,
  parameter int CTRL_WIDTH = pipe_pkg::CTRL_WIDTH,
  parameter int LANES = 1,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int TMP_W = DOUBLE_DATA_WIDTH,
  parameter int CNT_W = 2,
  parameter int ZERO_SUPPRESS = 1,
  parameter int PERF_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CTRL_WIDTH-1:0]     stall,
  input  logic                      flush,
  input  logic                      perf_clr,
  input  logic                      valid_in,
  input  logic [LANES*ADDR_W-1:0]   wb_addr_in,
  input  logic [LANES*DATA_W-1:0]   wb_data_in,
  input  logic [LANES-1:0]          wb_en_in,
  input  logic [DATA_W-1:0]         hi_in,
  input  logic [DATA_W-1:0]         lo_in,
  input  logic                      hilo_wen_in,
  input  logic [TMP_W-1:0]          tmp_in,
  input  logic [CNT_W-1:0]          cnt_in,
  output logic                      valid_out,
  output logic [LANES*ADDR_W-1:0]   wb_addr_out,
  output logic [LANES*DATA_W-1:0]   wb_data_out,
  output logic [LANES-1:0]          wb_en_out,
  output logic [DATA_W-1:0]         hi_out,
  output logic [DATA_W-1:0]         lo_out,
  output logic                      hilo_wen_out,
  output logic [TMP_W-1:0]          tmp_out,
  output logic [CNT_W-1:0]          cnt_out,
  output logic [PERF_W-1:0]         stall_cycles,
  output logic [PERF_W-1:0]         bubble_cycles
);
  if (STAGE + 1 >= CTRL_WIDTH) begin : g_bad_stage
    $error("ex_mem_stage: STAGE+1 must be below CTRL_WIDTH");
  end
  stage_op_e op;
  logic adv, hold, keep_scratch;
  logic [LANES-1:0] en_adv;
  logic valid_q, valid_d, hilo_wen_q, hilo_wen_d;
  logic [LANES*ADDR_W-1:0] addr_q, addr_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0] en_q, en_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [TMP_W-1:0] tmp_q, tmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign op = flush ? OP_FLUSH : !stall[STAGE] ? OP_ADV : !stall[STAGE+1] ? OP_BUBBLE : OP_HOLD;
  assign adv = op == OP_ADV;
  assign hold = op == OP_HOLD;
  assign keep_scratch = op == OP_BUBBLE || op == OP_HOLD;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign en_adv[i] = wb_en_in[i] & valid_in &
                       ~((ZERO_SUPPRESS != 0) && (wb_addr_in[i*ADDR_W +: ADDR_W] == '0));
  end
  always_comb begin
    valid_d = adv ? valid_in : hold ? valid_q : 1'b0;
    addr_d = adv ? wb_addr_in : hold ? addr_q : '0;
    data_d = adv ? wb_data_in : hold ? data_q : '0;
    en_d = adv ? en_adv : hold ? en_q : '0;
    hi_d = adv ? hi_in : hold ? hi_q : '0;
    lo_d = adv ? lo_in : hold ? lo_q : '0;
    hilo_wen_d = adv ? hilo_wen_in & valid_in : hold ? hilo_wen_q : 1'b0;
    tmp_d = keep_scratch ? tmp_in : '0;
    cnt_d = keep_scratch ? cnt_in : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      en_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      hilo_wen_q <= 1'b0;
      tmp_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q <= en_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      hilo_wen_q <= hilo_wen_d;
      tmp_q <= tmp_d;
      cnt_q <= cnt_d;
    end
  assign valid_out = valid_q;
  assign wb_addr_out = addr_q;
  assign wb_data_out = data_q;
  assign wb_en_out = en_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign hilo_wen_out = hilo_wen_q;
  assign tmp_out = tmp_q;
  assign cnt_out = cnt_q;
  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(!flush && stall[STAGE]), .clr(perf_clr), .cnt(stall_cycles)
  );
  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(op == OP_BUBBLE), .clr(perf_clr), .cnt(bubble_cycles)
  );
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus with a per-cycle behavioural model plus literal spot checks.
module tb_ex_mem_stage;
  localparam int LANES = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 4;
  localparam int SMAX = 2 ** PW - 1;
  logic clk = 0, rst = 1, flush = 0, perf_clr = 0, valid_in = 0, hilo_wen_in = 0;
  logic [5:0] stall = '0;
  logic [LANES*AW-1:0] wb_addr_in = '0;
  logic [LANES*DW-1:0] wb_data_in = '0;
  logic [LANES-1:0] wb_en_in = '0;
  logic [DW-1:0] hi_in = '0, lo_in = '0;
  logic [63:0] tmp_in = '0;
  logic [1:0] cnt_in = '0;
  logic valid_out, hilo_wen_out;
  logic [LANES*AW-1:0] wb_addr_out;
  logic [LANES*DW-1:0] wb_data_out;
  logic [LANES-1:0] wb_en_out;
  logic [DW-1:0] hi_out, lo_out;
  logic [63:0] tmp_out;
  logic [1:0] cnt_out;
  logic [PW-1:0] stall_cycles, bubble_cycles;
  int checks = 0, errors = 0;
  ex_mem_stage #(.STAGE(3), .CTRL_WIDTH(6), .LANES(LANES), .ADDR_W(AW), .DATA_W(DW),
                 .TMP_W(64), .CNT_W(2), .ZERO_SUPPRESS(1), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .valid_in(valid_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .wb_en_in(wb_en_in),
    .hi_in(hi_in), .lo_in(lo_in), .hilo_wen_in(hilo_wen_in), .tmp_in(tmp_in), .cnt_in(cnt_in),
    .valid_out(valid_out), .wb_addr_out(wb_addr_out), .wb_data_out(wb_data_out),
    .wb_en_out(wb_en_out), .hi_out(hi_out), .lo_out(lo_out), .hilo_wen_out(hilo_wen_out),
    .tmp_out(tmp_out), .cnt_out(cnt_out), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );
  always #5 clk = ~clk;
  int m_valid = 0, m_hilo = 0, m_cnt = 0, m_stall = 0, m_bubble = 0;
  int m_addr[LANES] = '{default: 0};
  int m_en[LANES] = '{default: 0};
  longint m_data[LANES] = '{default: 0};
  longint m_hi = 0, m_lo = 0, m_tmp = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_hilo = 0; m_cnt = 0; m_stall = 0; m_bubble = 0; m_hi = 0; m_lo = 0; m_tmp = 0;
      for (int i = 0; i < LANES; i++) begin m_addr[i] = 0; m_en[i] = 0; m_data[i] = 0; end
    end else begin
      if (perf_clr) begin
        m_stall = 0; m_bubble = 0;
      end else if (!flush && stall[3]) begin
        m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
        if (!stall[4]) m_bubble = (m_bubble == SMAX) ? SMAX : m_bubble + 1;
      end
      if (flush || (stall[3] && !stall[4])) begin
        m_valid = 0; m_hilo = 0; m_hi = 0; m_lo = 0;
        for (int i = 0; i < LANES; i++) begin m_addr[i] = 0; m_en[i] = 0; m_data[i] = 0; end
      end else if (!stall[3]) begin
        m_valid = int'(valid_in); m_hi = longint'(hi_in); m_lo = longint'(lo_in);
        m_hilo = int'(hilo_wen_in && valid_in);
        for (int i = 0; i < LANES; i++) begin
          m_addr[i] = int'(wb_addr_in[i*AW +: AW]);
          m_data[i] = longint'(wb_data_in[i*DW +: DW]);
          m_en[i] = int'(wb_en_in[i] && valid_in && m_addr[i] != 0);
        end
      end
      m_tmp = (!flush && stall[3]) ? longint'(tmp_in) : 0;
      m_cnt = (!flush && stall[3]) ? int'(cnt_in) : 0;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("valid_out", 64'(valid_out), 64'(m_valid));
    chk("hilo_wen_out", 64'(hilo_wen_out), 64'(m_hilo));
    chk("hi_out", 64'(hi_out), 64'(m_hi));
    chk("lo_out", 64'(lo_out), 64'(m_lo));
    chk("tmp_out", tmp_out, 64'(m_tmp));
    chk("cnt_out", 64'(cnt_out), 64'(m_cnt));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("bubble_cycles", 64'(bubble_cycles), 64'(m_bubble));
    for (int i = 0; i < LANES; i++) begin
      chk("wb_addr_out", 64'(wb_addr_out[i*AW +: AW]), 64'(m_addr[i]));
      chk("wb_data_out", 64'(wb_data_out[i*DW +: DW]), 64'(m_data[i]));
      chk("wb_en_out", 64'(wb_en_out[i]), 64'(m_en[i]));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("reset valid", 64'(valid_out), 64'd0);
    chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
    chk("reset tmp", tmp_out, 64'd0);
    valid_in = 1; wb_addr_in = {5'd0, 5'd3}; wb_data_in = {32'h0, 32'hDEADBEEF};
    wb_en_in = 2'b01; cnt_in = 2; tmp_in = 64'hFFFF;
    tick();
    chk("adv data", 64'(wb_data_out[31:0]), 64'hDEADBEEF);
    chk("adv valid", 64'(valid_out), 64'd1);
    chk("adv cnt", 64'(cnt_out), 64'd0);
    #2 rst = 1;
    #1;
    chk("async rst valid", 64'(valid_out), 64'd0);
    chk("async rst data", 64'(wb_data_out), 64'd0);
    chk("async rst en", 64'(wb_en_out), 64'd0);
    tick();
    rst = 0;
    wb_addr_in = {5'd7, 5'd0}; wb_data_in = {32'h1234, 32'h55}; wb_en_in = 2'b11;
    hilo_wen_in = 1; hi_in = 32'h11; lo_in = 32'h22;
    tick();
    chk("zero suppress en", 64'(wb_en_out), 64'b10);
    chk("lane1 data", 64'(wb_data_out[63:32]), 64'h1234);
    chk("lane valid", 64'(valid_out), 64'd1);
    chk("hilo_wen", 64'(hilo_wen_out), 64'd1);
    chk("hi", 64'(hi_out), 64'h11);
    valid_in = 0; wb_addr_in = {5'd5, 5'd5};
    tick();
    chk("invalid en", 64'(wb_en_out), 64'd0);
    chk("invalid hilo", 64'(hilo_wen_out), 64'd0);
    chk("invalid addr", 64'(wb_addr_out), 64'({5'd5, 5'd5}));
    stall = 6'b001000; tmp_in = 64'h0000_0001_0000_0002; cnt_in = 1; valid_in = 1;
    tick();
    chk("bubble valid", 64'(valid_out), 64'd0);
    chk("bubble en", 64'(wb_en_out), 64'd0);
    chk("bubble tmp", tmp_out, 64'h0000_0001_0000_0002);
    chk("bubble cnt", 64'(cnt_out), 64'd1);
    chk("bubble count", 64'(bubble_cycles), 64'd1);
    chk("bubble stall count", 64'(stall_cycles), 64'd1);
    stall = 0; wb_addr_in = {5'd0, 5'd1}; wb_data_in = {32'h0, 32'hA5}; wb_en_in = 2'b01;
    tick();
    chk("A5 data", 64'(wb_data_out[31:0]), 64'hA5);
    chk("A5 tmp", tmp_out, 64'd0);
    stall = 6'b011000; wb_data_in = {32'h0, 32'hFF}; cnt_in = 2; tmp_in = 64'h77;
    repeat (3) tick();
    chk("hold data", 64'(wb_data_out[31:0]), 64'hA5);
    chk("hold valid", 64'(valid_out), 64'd1);
    chk("hold stall count", 64'(stall_cycles), 64'd4);
    chk("hold bubble count", 64'(bubble_cycles), 64'd1);
    chk("hold cnt", 64'(cnt_out), 64'd2);
    flush = 1;
    tick();
    flush = 0;
    chk("flush tmp", tmp_out, 64'd0);
    chk("flush cnt", 64'(cnt_out), 64'd0);
    chk("flush valid", 64'(valid_out), 64'd0);
    chk("flush stall count", 64'(stall_cycles), 64'd4);
    repeat (20) tick();
    chk("saturate", 64'(stall_cycles), 64'd15);
    stall = 6'b001000; perf_clr = 1;
    tick();
    chk("clr stall count", 64'(stall_cycles), 64'd0);
    chk("clr bubble count", 64'(bubble_cycles), 64'd0);
    flush = 1;
    tick();
    flush = 0; perf_clr = 0;
    chk("flush clr stall", 64'(stall_cycles), 64'd0);
    tick();
    chk("post clr stall", 64'(stall_cycles), 64'd1);
    chk("post clr bubble", 64'(bubble_cycles), 64'd1);
    stall = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
